// File: rtl/mspu_dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mspu_dma_pkg                                                         |
// | Line geometry and DMA state encoding shared by loader and unloader.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mspu_dma_pkg;

  localparam int LINE_WORDS = 16;
  localparam int LINE_BYTES = 64;
  localparam int LINE_BITS  = 512;
  localparam int WORD_BITS  = 32;
  localparam int LINE_SHIFT = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/word_line_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_line_packer                                                     |
// | 32-to-512 MSB-first shift register; first word lands in [511:480].   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module word_line_packer
  import mspu_dma_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic [WORD_BITS-1:0] din,
  output logic [LINE_BITS-1:0] line_next
);

  logic [LINE_BITS-1:0] r_line;
  logic                 unused_top_word;

  // line_next is the line as it stands once din is shifted in, so the
  // caller can capture a completed line on the same edge as the last shift.
  assign line_next       = {r_line[LINE_BITS-WORD_BITS-1:0], din};
  assign unused_top_word = ^r_line[LINE_BITS-1 -: WORD_BITS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line <= '0;
    end else if (clr) begin
      r_line <= '0;
    end else if (shift_en) begin
      r_line <= line_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_unloader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_unloader                                                        |
// | Reads a core's data memory line by line and writes it over Avalon-MM.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module data_unloader
  import mspu_dma_pkg::*;
#(
  parameter  int CORES      = 4,
  parameter  int DMEM_DEPTH = 14,
  localparam int CORE_W     = (CORES > 1) ? $clog2(CORES) : 1,
  localparam int ADDR_W     = CORE_W + DMEM_DEPTH + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  kick,
  output logic                  busy,
  output logic                  done,
  input  logic [63:0]           memory_base_addr,
  input  logic [CORE_W-1:0]     target_core,
  input  logic [DMEM_DEPTH-1:0] start_word,
  input  logic [15:0]           num_lines,
  output logic [ADDR_W-1:0]     data_addr,
  output logic                  data_re,
  input  logic [WORD_BITS-1:0]  data_din,
  input  logic                  m0_waitrequest,
  input  logic [LINE_BITS-1:0]  m0_readdata,
  input  logic                  m0_readdatavalid,
  output logic [2:0]            m0_burstcount,
  output logic [LINE_BITS-1:0]  m0_writedata,
  output logic [63:0]           m0_address,
  output logic                  m0_write,
  output logic                  m0_read,
  output logic [LINE_BYTES-1:0] m0_byteenable,
  output logic                  m0_debugaccess
);

  dma_state_e            r_state;
  dma_state_e            w_next_state;
  logic [4:0]            r_word_cnt;
  logic [15:0]           r_line_cnt;
  logic [15:0]           r_num_lines;
  logic [63:0]           r_base;
  logic [CORE_W-1:0]     r_core;
  logic [DMEM_DEPTH-1:0] r_rd_idx;
  logic                  r_busy;

  logic                  w_start;
  logic                  w_start_xfer;
  logic                  w_start_empty;
  logic                  w_issue;
  logic                  w_shift;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_refill;
  logic [LINE_BITS-1:0]  w_line;
  logic                  unused_read_port;

  assign busy             = r_busy | kick;
  assign m0_burstcount    = 3'd1;
  assign m0_read          = 1'b0;
  assign m0_debugaccess   = 1'b0;
  assign unused_read_port = ^{m0_readdata, m0_readdatavalid};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start_xfer) w_next_state = ST_FILL;
      ST_FILL:  if (w_load)       w_next_state = ST_WRITE;
      ST_WRITE: if (w_accept)     w_next_state = w_last ? ST_IDLE : ST_FILL;
      default:                    w_next_state = ST_IDLE;
    endcase
  end

  // Reads are issued one cycle ahead of use: word k is requested while
  // word_cnt==k and shifted in while word_cnt==k+1.
  always_comb begin
    w_start       = (r_state == ST_IDLE) && kick;
    w_start_xfer  = w_start && (num_lines != 16'd0);
    w_start_empty = w_start && (num_lines == 16'd0);
    w_issue       = (r_state == ST_FILL) && (r_word_cnt < 5'(LINE_WORDS - 1));
    w_shift       = (r_state == ST_FILL) && (r_word_cnt != 5'd0);
    w_load        = (r_state == ST_FILL) && (r_word_cnt == 5'(LINE_WORDS));
    w_accept      = (r_state == ST_WRITE) && m0_write && !m0_waitrequest;
    w_last        = w_accept && ((r_line_cnt + 16'd1) == r_num_lines);
    w_refill      = w_accept && !w_last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_cnt    <= '0;
      r_line_cnt    <= '0;
      r_num_lines   <= '0;
      r_base        <= '0;
      r_core        <= '0;
      r_rd_idx      <= '0;
      r_busy        <= 1'b0;
      done          <= 1'b0;
      data_re       <= 1'b0;
      data_addr     <= '0;
      m0_write      <= 1'b0;
      m0_address    <= '0;
      m0_writedata  <= '0;
      m0_byteenable <= '0;
    end else begin
      done    <= w_start_empty | w_last;
      data_re <= w_start_xfer | w_issue | w_refill;

      if (w_start) begin
        r_base      <= memory_base_addr;
        r_core      <= target_core;
        r_num_lines <= num_lines;
        r_line_cnt  <= '0;
      end

      // The read index runs contiguously across lines and wraps naturally.
      if (w_start_xfer) begin
        r_busy    <= 1'b1;
        data_addr <= {target_core, start_word, 2'b00};
        r_rd_idx  <= start_word + DMEM_DEPTH'(1);
      end else if (w_issue || w_refill) begin
        data_addr <= {r_core, r_rd_idx, 2'b00};
        r_rd_idx  <= r_rd_idx + DMEM_DEPTH'(1);
      end

      if (w_start_xfer || w_refill) begin
        r_word_cnt <= '0;
      end else if ((r_state == ST_FILL) && !w_load) begin
        r_word_cnt <= r_word_cnt + 5'd1;
      end

      if (w_load) begin
        m0_writedata  <= w_line;
        m0_address    <= r_base + (64'(r_line_cnt) << LINE_SHIFT);
        m0_write      <= 1'b1;
        m0_byteenable <= '1;
      end

      if (w_accept) begin
        m0_write      <= 1'b0;
        m0_byteenable <= '0;
        r_line_cnt    <= r_line_cnt + 16'd1;
      end

      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  word_line_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (w_start_xfer),
    .shift_en  (w_shift),
    .din       (data_din),
    .line_next (w_line)
  );

endmodule
`default_nettype wire

// File: doc/data_unloader.md
# data_unloader

Downstream counterpart of the per-core memory loader: after a core finishes, it reads a contiguous region of that core's data memory and writes it to host memory over Avalon-MM. Each 64-byte line is assembled from 16 consecutive 32-bit words, MSB-first, matching the loader's unpacking order. It sits between the core data-memory read port mux and the shared Avalon-MM master arbiter.

## Interface
- CORES, 4, number of cores; selects the core field width
- DMEM_DEPTH, 14, log2 of data-memory words per core
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- kick  in  1  start request; sampled in IDLE only
- busy  out  1  busy_reg OR kick
- done  out  1  one-cycle pulse when the last line write is accepted
- memory_base_addr  in  64  host byte address of line 0; 64-byte aligned
- target_core  in  clog2(CORES)  core whose data memory is unloaded
- start_word  in  DMEM_DEPTH  first data-memory word index
- num_lines  in  16  number of 64-byte lines to transfer; 0 means no transfer
- data_addr  out  clog2(CORES)+DMEM_DEPTH+2  {core, word index, 2'b00} byte address
- data_re  out  1  data-memory read enable
- data_din  in  32  read data, valid exactly one cycle after data_re
- m0_waitrequest  in  1  Avalon-MM stall
- m0_readdata  in  512  unused
- m0_readdatavalid  in  1  unused
- m0_burstcount  out  3  constant 1
- m0_writedata  out  512  assembled line
- m0_address  out  64  host byte address
- m0_write  out  1  write request
- m0_read  out  1  constant 0
- m0_byteenable  out  64  all ones while m0_write=1, otherwise 0
- m0_debugaccess  out  1  constant 0

## Operation
- States: IDLE, FILL, WRITE.
- IDLE: on kick=1, capture memory_base_addr, target_core, start_word, and num_lines, and clear line_cnt.
  - If num_lines=0: stay in IDLE and pulse done on the next cycle.
  - Otherwise: enter FILL with word_cnt=0 and busy_reg=1.
- FILL, which runs word_cnt 0..16:
  - For word_cnt<16: data_re=1 and the word index is start_word + line_cnt*16 + word_cnt, truncated modulo 2^DMEM_DEPTH so the index wraps to 0.
  - For word_cnt≥1: shift register <= {shreg[479:0], data_din}. The first word therefore ends in [511:480].
  - At word_cnt=16: load m0_writedata from the completed line, set m0_address = base + line_cnt*64 (64-bit wrap), set m0_write=1 and m0_byteenable all ones, then go to WRITE.
- WRITE: hold m0_address, m0_writedata, and m0_write stable while m0_waitrequest=1.
  - On the first cycle with m0_write=1 and m0_waitrequest=0: drop m0_write and m0_byteenable, and increment line_cnt.
  - If the incremented line_cnt equals num_lines: go to IDLE, set done=1 for one cycle, and clear busy_reg.
  - Otherwise: go to FILL with word_cnt=0.
- kick while not in IDLE is ignored; captured parameters do not change mid-transfer.
- Reset assertion at any time aborts the transfer immediately. There is no partial write completion, and no further m0_write is issued.
- Reset values: busy_reg 0, done 0, data_re 0, data_addr 0, m0_write 0, m0_read 0, m0_address 0, m0_writedata 0, m0_byteenable 0, m0_burstcount 1, m0_debugaccess 0. State resets to IDLE.

## Timing
- All outputs are registered except busy, which is combinational: busy_reg | kick.
- Line cost is 17 FILL cycles plus 1 + W WRITE cycles, where W is the number of stall cycles. With no stalls this is 18 cycles per line.
- A kick sampled at edge 0 gives FILL on cycles 1..17 and m0_write visible from cycle 18.
- data_re and data_addr are both registered; data_din is consumed one cycle after the corresponding data_re.
- done is asserted in the cycle after the accepting edge, coincident with busy_reg=0.
- The next kick is accepted in the cycle in which done=1.

## Structure
- Shared package mspu_dma_pkg:
  - LINE_WORDS=16
  - LINE_BYTES=64
  - LINE_BITS=512
  - the state enum
  - The loader uses the same constants.
- One sub-module, word_line_packer: a 32-to-512 MSB-first shift register with clear and shift-enable.

## Test plan
- **Single line, no stalls:** num_lines=1, base=0x1000, core 2, start_word=0, dmem words 0..15 = 0x00..0x0F.
  - One write at 0x1000 with writedata[511:480]=0, [31:0]=0x0F.
  - done pulses 18 cycles after kick.
- **Three lines, waitrequest high for 5 cycles on the second line:**
  - Addresses 0x1000, 0x1040, 0x1080, with address and data held stable during the stall.
  - done arrives 3×18+5 cycles after kick.
- **num_lines=0:** no data_re and no m0_write; done pulses the cycle after kick; busy falls after the kick cycle.
- **Wrap-around:** start_word=2^DMEM_DEPTH−8, one line.
  - Words 8..15 of the line are read from indices 0..7.
  - data_addr carries the target_core field throughout.
- **Reset mid-transfer:** assert reset during FILL of line 2 of 4, then release.
  - All outputs equal their reset values and no further m0_write occurs.
  - A new kick then runs correctly.
- **kick during busy:** the extra kick is ignored; the write count equals the original num_lines.
